// File: rtl/sad_min_tracker.sv
`default_nettype none
// ============================================================================
// Module      : sad_min_tracker
// Description : Sums BLK_ROWS rows of N_PE absolute differences into one
//               candidate SAD, scans SR_W*SR_H candidates in raster order and
//               returns the minimum SAD and its motion vector via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_min_tracker #(
    parameter int N_PE     = 16,
    parameter int AD_W     = 8,
    parameter int BLK_ROWS = 16,
    parameter int SR_W     = 8,
    parameter int SR_H     = 8,
    parameter int SAD_W    = 16,
    localparam int c_X_W   = (SR_W > 1) ? $clog2(SR_W) : 1,
    localparam int c_Y_W   = (SR_H > 1) ? $clog2(SR_H) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   ad_valid,
    input  logic [N_PE*AD_W-1:0]   ad_bus,
    output logic                   busy,
    output logic                   mv_valid,
    input  logic                   mv_ready,
    output logic [c_X_W-1:0]       mv_x,
    output logic [c_Y_W-1:0]       mv_y,
    output logic [SAD_W-1:0]       min_sad
);

    localparam int c_B_W = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;

    localparam logic [c_B_W-1:0] c_BEAT_LAST = c_B_W'(BLK_ROWS - 1);
    localparam logic [c_X_W-1:0] c_X_LAST    = c_X_W'(SR_W - 1);
    localparam logic [c_Y_W-1:0] c_Y_LAST    = c_Y_W'(SR_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Beat / candidate position of the next beat to be accepted
    logic [c_B_W-1:0] r_beat;
    logic [c_X_W-1:0] r_cand_x;
    logic [c_Y_W-1:0] r_cand_y;

    logic w_go;
    logic w_beat_ok;
    logic w_beat_last;
    logic w_final;
    logic [SAD_W-1:0] w_row_sum;

    // Stage 1: registered row sum plus the candidate tag
    logic             r_s1_valid;
    logic [SAD_W-1:0] r_s1_sum;
    logic             r_s1_first;
    logic             r_s1_last;
    logic             r_s1_final;
    logic [c_X_W-1:0] r_s1_x;
    logic [c_Y_W-1:0] r_s1_y;

    // Stage 2: accumulator
    logic [SAD_W-1:0] r_acc;
    logic             r_cand_done;
    logic             r_s2_final;
    logic [c_X_W-1:0] r_s2_x;
    logic [c_Y_W-1:0] r_s2_y;

    // Stage 3: running best
    logic [SAD_W-1:0] r_best_sad;
    logic [c_X_W-1:0] r_best_x;
    logic [c_Y_W-1:0] r_best_y;
    logic             r_s3_final;

    logic [SAD_W-1:0] r_min_sad;
    logic [c_X_W-1:0] r_mv_x;
    logic [c_Y_W-1:0] r_mv_y;

    assign w_go        = (r_state == S_IDLE) && start;
    assign w_beat_ok   = (r_state == S_ACCUM) && ad_valid;
    assign w_beat_last = (r_beat == c_BEAT_LAST);
    assign w_final     = w_beat_ok && w_beat_last &&
                         (r_cand_x == c_X_LAST) && (r_cand_y == c_Y_LAST);

    always_comb begin
        w_row_sum = '0;
        for (int k = 0; k < N_PE; k++) begin
            w_row_sum = w_row_sum + SAD_W'(ad_bus[k*AD_W +: AD_W]);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)      w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_final)    w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_s3_final) w_state_nxt = S_DONE;
            S_DONE:  if (mv_ready)   w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat and candidate counters; y saturates on the final candidate
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_go) begin
            r_beat   <= '0;
            r_cand_x <= '0;
            r_cand_y <= '0;
        end else if (w_beat_ok) begin
            if (w_beat_last) begin
                r_beat <= '0;
                if (r_cand_x == c_X_LAST) begin
                    r_cand_x <= '0;
                    if (r_cand_y != c_Y_LAST) begin
                        r_cand_y <= r_cand_y + c_Y_W'(1);
                    end
                end else begin
                    r_cand_x <= r_cand_x + c_X_W'(1);
                end
            end else begin
                r_beat <= r_beat + c_B_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_final <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
        end else begin
            r_s1_valid <= w_beat_ok;
            if (w_beat_ok) begin
                r_s1_sum   <= w_row_sum;
                r_s1_first <= (r_beat == '0);
                r_s1_last  <= w_beat_last;
                r_s1_final <= w_final;
                r_s1_x     <= r_cand_x;
                r_s1_y     <= r_cand_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cand_done <= 1'b0;
            r_s2_final  <= 1'b0;
            r_s2_x      <= '0;
            r_s2_y      <= '0;
        end else begin
            r_cand_done <= r_s1_valid && r_s1_last;
            r_s2_final  <= r_s1_valid && r_s1_final;
            if (r_s1_valid) begin
                r_acc  <= r_s1_first ? r_s1_sum : (r_acc + r_s1_sum);
                r_s2_x <= r_s1_x;
                r_s2_y <= r_s1_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: strict less-than so a tie keeps the earlier candidate
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_go) begin
            r_best_sad <= '1;
            r_best_x   <= '0;
            r_best_y   <= '0;
            r_s3_final <= 1'b0;
        end else begin
            r_s3_final <= r_s2_final;
            if (r_cand_done && (r_acc < r_best_sad)) begin
                r_best_sad <= r_acc;
                r_best_x   <= r_s2_x;
                r_best_y   <= r_s2_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers, loaded only on DONE entry
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_min_sad <= '1;
            r_mv_x    <= '0;
            r_mv_y    <= '0;
        end else if ((r_state == S_DRAIN) && r_s3_final) begin
            r_min_sad <= r_best_sad;
            r_mv_x    <= r_best_x;
            r_mv_y    <= r_best_y;
        end
    end

    assign busy     = (r_state == S_ACCUM) || (r_state == S_DRAIN);
    assign mv_valid = (r_state == S_DONE);
    assign mv_x     = r_mv_x;
    assign mv_y     = r_mv_y;
    assign min_sad  = r_min_sad;

endmodule
`default_nettype wire

// File: tb/tb_sad_min_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sad_min_tracker
// Description : Scoreboard bench for sad_min_tracker with directed searches.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_min_tracker;

    localparam int N_PE = 16;
    localparam int AD_W = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 ad_valid;
    logic [N_PE*AD_W-1:0] ad_bus;
    logic                 busy;
    logic                 mv_valid;
    logic                 mv_ready;
    logic [2:0]           mv_x;
    logic [2:0]           mv_y;
    logic [15:0]          min_sad;

    typedef struct packed {
        logic [15:0] sad;
        logic [2:0]  x;
        logic [2:0]  y;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    sad_min_tracker dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ad_valid (ad_valid),
        .ad_bus   (ad_bus),
        .busy     (busy),
        .mv_valid (mv_valid),
        .mv_ready (mv_ready),
        .mv_x     (mv_x),
        .mv_y     (mv_y),
        .min_sad  (min_sad)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Directed data sets; expected results below are worked out by hand
    function automatic logic [7:0] ad_val(input int mode, input int x, input int y, input int k);
        case (mode)
            0: return (x == 3 && y == 5) ? 8'd0 : 8'd1;
            1: return 8'd2;
            2: return 8'hFF;
            3: return (x == 6 && y == 2 && k == 15) ? 8'd0 : 8'(k);
            4: return ((x == 4 && y == 4) || (x == 1 && y == 6)) ? 8'd1 : 8'd5;
            5: return 8'(200 - (y * 8 + x));
            default: return 8'd0;
        endcase
    endfunction

    // Monitor: pops one expectation per accepted result
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && mv_valid && mv_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result actual=%0h required=none", min_sad);
                end else begin
                    e = exp_q.pop_front();
                    check("min_sad", min_sad, e.sad);
                    check("mv_x", mv_x, e.x);
                    check("mv_y", mv_y, e.y);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // All driver actions happen 2 time units after a rising edge
    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic drive_beats(input int mode, input int gaps, input int max_beats);
        int n = 0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                for (int r = 0; r < 16; r++) begin
                    if (n == max_beats) begin
                        ad_valid = 1'b0;
                        return;
                    end
                    if (gaps > 0) begin
                        repeat ($urandom_range(0, gaps)) begin
                            ad_valid = 1'b0;
                            ad_bus   = '1;
                            @(posedge clk); #2;
                        end
                    end
                    for (int k = 0; k < N_PE; k++) begin
                        ad_bus[k*AD_W +: AD_W] = ad_val(mode, x, y, k);
                    end
                    ad_valid = 1'b1;
                    start    = (gaps > 0) && (n == 500);
                    @(posedge clk); #2;
                    start = 1'b0;
                    n++;
                end
            end
        end
        ad_valid = 1'b0;
    endtask

    task automatic run_search(input int mode, input res_t e, input int gaps, input bit hold);
        int edges;
        exp_q.push_back(e);
        do_start();
        check("busy_on_start", busy, 1);
        drive_beats(mode, gaps, 1 << 30);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!mv_valid && edges < 20);
        check("latency", edges, 3);
        check("busy_in_done", busy, 0);
        if (hold) begin
            repeat (10) begin
                @(posedge clk); #1;
                check("hold_valid", mv_valid, 1);
                check("hold_sad", min_sad, e.sad);
                check("hold_mv", {mv_x, mv_y}, {e.x, e.y});
            end
            #1;
            mv_ready = 1'b1;
            @(posedge clk); #1;
            check("valid_drop", mv_valid, 0);
        end else begin
            edges = 0;
            while (mv_valid && edges < 20) begin
                @(posedge clk); #1;
                edges++;
            end
            check("valid_release", mv_valid, 0);
        end
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        ad_valid = 1'b0;
        ad_bus   = '0;
        mv_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", mv_valid, 0);
        check("rst_sad", min_sad, 16'hFFFF);
        check("rst_mv", {mv_x, mv_y}, 6'd0);
        #1;
        rst = 1'b0;
        @(posedge clk); #2;

        run_search(0, '{sad: 16'd0,     x: 3'd3, y: 3'd5}, 0, 1'b0);
        run_search(1, '{sad: 16'd512,   x: 3'd0, y: 3'd0}, 0, 1'b0);
        run_search(2, '{sad: 16'hFF00,  x: 3'd0, y: 3'd0}, 0, 1'b0);
        run_search(3, '{sad: 16'd1680,  x: 3'd6, y: 3'd2}, 0, 1'b0);
        run_search(4, '{sad: 16'd256,   x: 3'd4, y: 3'd4}, 0, 1'b0);
        run_search(5, '{sad: 16'd35072, x: 3'd7, y: 3'd7}, 0, 1'b0);

        mv_ready = 1'b0;
        run_search(0, '{sad: 16'd0, x: 3'd3, y: 3'd5}, 2, 1'b1);

        // Abort after 100 beats; nothing from that search may appear
        do_start();
        drive_beats(2, 0, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_valid", mv_valid, 0);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_stale", mv_valid, 0);
        #1;
        run_search(0, '{sad: 16'd0, x: 3'd3, y: 3'd5}, 0, 1'b0);

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
